// File: rtl/ram_bank_controller.sv
// ---------------------------------------------------------------------------
// ram_bank_controller
//
// Maps the window [BASE_ADDR, BASE_ADDR + (NUM_BANKS << BANK_ADDR_W)) of the
// CPU byte address space onto NUM_BANKS byte-interleaved synchronous SRAM
// macros. The macros share address, data and chip-enable lines. Each macro
// has its own active-low global write enable. Consecutive bytes land in
// consecutive banks. After reset (when CLEAR_ON_RESET), or when clear_start
// is pulsed, a zero-fill sequencer writes 0 to every row of every bank.
//
// Ports
//   wb_clk_i     clock, rising edge
//   rst          synchronous reset, active high
//   ram_enabled  global enable; when 0, accesses miss
//   req_valid    request present
//   req_ready    request accepted when req_valid && req_ready
//   req_we       1 = write, 0 = read
//   req_addr     byte address
//   req_wdata    write data
//   clear_start  pulse; starts zero-fill from IDLE
//   busy         zero-fill in progress
//   rsp_valid    read response valid (one cycle after an accepted read)
//   rsp_hit      response address was in window and enabled
//   rsp_rdata    read data; 0 on miss
//   CEN_all      shared chip enable, active low
//   WEN_all      bit-write mask, active low; constant 0
//   A_all        shared row address
//   D_all        shared write data
//   GWEN         per-bank global write enable, active low
//   Q_flat       macro outputs; bank k at [k*DATA_W +: DATA_W]
// ---------------------------------------------------------------------------
module ram_bank_controller #(
  parameter int                NUM_BANKS      = 8,
  parameter int                BANK_ADDR_W    = 9,
  parameter int                DATA_W         = 8,
  parameter int                ADDR_W         = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic                        wb_clk_i,
  input  logic                        rst,
  input  logic                        ram_enabled,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [DATA_W-1:0]           req_wdata,
  input  logic                        clear_start,
  output logic                        busy,
  output logic                        rsp_valid,
  output logic                        rsp_hit,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        CEN_all,
  output logic [DATA_W-1:0]           WEN_all,
  output logic [BANK_ADDR_W-1:0]      A_all,
  output logic [DATA_W-1:0]           D_all,
  output logic [NUM_BANKS-1:0]        GWEN,
  input  logic [NUM_BANKS*DATA_W-1:0] Q_flat
);

  localparam int BS   = $clog2(NUM_BANKS);
  localparam int SIZE = NUM_BANKS << BANK_ADDR_W;

  localparam logic [ADDR_W:0]        SIZE_EXT = (ADDR_W + 1)'(SIZE);
  localparam logic [ADDR_W:0]        BASE_EXT = {1'b0, BASE_ADDR};
  localparam logic [BANK_ADDR_W-1:0] CLR_LAST = '1;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [BANK_ADDR_W-1:0] r_clr_cnt;
  logic [BANK_ADDR_W-1:0] w_next_clr_cnt;
  logic                   r_rsp_valid;
  logic                   r_rsp_hit;
  logic [BS-1:0]          r_rsp_bank;

  // Address decode. The offset carries one extra bit so that an address
  // below BASE_ADDR wraps to a large value and cannot alias into the window.
  logic [ADDR_W:0]        w_off;
  logic                   w_in_range;
  logic                   w_hit;
  logic [BS-1:0]          w_bank;
  logic [BANK_ADDR_W-1:0] w_row;
  logic                   w_ready;
  logic                   w_accept;

  assign w_off      = {1'b0, req_addr} - BASE_EXT;
  assign w_in_range = (req_addr >= BASE_ADDR) && (w_off < SIZE_EXT);
  assign w_hit      = w_in_range && ram_enabled;
  assign w_bank     = w_off[BS-1:0];
  assign w_row      = w_off[BS+BANK_ADDR_W-1:BS];

  // NOTE: state registers use non-blocking assignments, so every flop in this
  // block samples pre-edge values regardless of statement order.
  always_ff @(posedge wb_clk_i) begin
    if (rst) begin
      r_state     <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      r_clr_cnt   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_hit   <= 1'b0;
      r_rsp_bank  <= '0;
    end else begin
      r_state     <= w_next_state;
      r_clr_cnt   <= w_next_clr_cnt;
      r_rsp_valid <= w_accept && !req_we;
      // rsp_hit is only asserted alongside rsp_valid.
      r_rsp_hit   <= w_accept && !req_we && w_hit;
      if (w_accept && !req_we) begin
        r_rsp_bank <= w_bank;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_next_state   = r_state;
    w_next_clr_cnt = r_clr_cnt;
    w_ready        = 1'b0;
    w_accept       = 1'b0;
    busy           = 1'b0;
    CEN_all        = 1'b1;
    GWEN           = '1;
    A_all          = '0;
    D_all          = '0;
    // While rst is high the macros stay deselected and no request is taken.
    if (!rst) begin
      unique case (r_state)
        S_CLEAR: begin
          busy           = 1'b1;
          CEN_all        = 1'b0;
          GWEN           = '0;
          A_all          = r_clr_cnt;
          w_next_clr_cnt = r_clr_cnt + 1'b1;
          if (r_clr_cnt == CLR_LAST) begin
            w_next_state   = S_IDLE;
            w_next_clr_cnt = '0;
          end
        end
        S_IDLE: begin
          // A clear request wins over a request arriving in the same cycle.
          w_ready  = !clear_start;
          w_accept = req_valid && w_ready;
          if (clear_start) begin
            w_next_state   = S_CLEAR;
            w_next_clr_cnt = '0;
          end else if (w_accept) begin
            A_all        = w_row;
            D_all        = req_wdata;
            CEN_all      = !w_hit;
            GWEN[w_bank] = !(w_hit && req_we);
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = w_ready;
  assign WEN_all   = '0;
  assign rsp_valid = r_rsp_valid;
  assign rsp_hit   = r_rsp_hit;
  // The macros present read data in the cycle after the access, so the bank
  // select is registered and the data mux is combinational.
  assign rsp_rdata = r_rsp_hit ? Q_flat[int'(r_rsp_bank)*DATA_W +: DATA_W]
                               : '0;

endmodule

// File: tb/tb_ram_bank_controller.sv
// ---------------------------------------------------------------------------
// tb_ram_bank_controller
//
// Two controllers run side by side on one clock: unit 0 uses default
// parameters, and unit 1 uses BASE_ADDR = 16'h1000 with no clear on reset.
// Each unit drives a behavioural model of eight write-first SRAM macros.
// Expected results come from a flat byte-array model of each window.
// ---------------------------------------------------------------------------
module tb_ram_bank_controller;

  localparam int WIN = 4096;

  logic       wb_clk_i = 1'b0;
  logic       rst;
  logic       ram_en      [2];
  logic       req_valid   [2];
  logic       req_we      [2];
  logic       clear_start [2];
  logic [15:0] req_addr   [2];
  logic [7:0]  req_wdata  [2];
  logic       req_ready   [2];
  logic       busy        [2];
  logic       rsp_valid   [2];
  logic       rsp_hit     [2];
  logic       cen         [2];
  logic [7:0] rsp_rdata   [2];
  logic [7:0] wen         [2];
  logic [7:0] d_all       [2];
  logic [7:0] gwen        [2];
  logic [8:0] a_all       [2];
  logic [63:0] q_flat     [2];

  always #5 wb_clk_i = ~wb_clk_i;

  ram_bank_controller dut_a (
    .wb_clk_i(wb_clk_i), .rst(rst), .ram_enabled(ram_en[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .clear_start(clear_start[0]), .busy(busy[0]),
    .rsp_valid(rsp_valid[0]), .rsp_hit(rsp_hit[0]), .rsp_rdata(rsp_rdata[0]),
    .CEN_all(cen[0]), .WEN_all(wen[0]), .A_all(a_all[0]), .D_all(d_all[0]),
    .GWEN(gwen[0]), .Q_flat(q_flat[0])
  );

  ram_bank_controller #(.BASE_ADDR(16'h1000), .CLEAR_ON_RESET(1'b0)) dut_b (
    .wb_clk_i(wb_clk_i), .rst(rst), .ram_enabled(ram_en[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .clear_start(clear_start[1]), .busy(busy[1]),
    .rsp_valid(rsp_valid[1]), .rsp_hit(rsp_hit[1]), .rsp_rdata(rsp_rdata[1]),
    .CEN_all(cen[1]), .WEN_all(wen[1]), .A_all(a_all[1]), .D_all(d_all[1]),
    .GWEN(gwen[1]), .Q_flat(q_flat[1])
  );

  // Behavioural SRAM macros: sampled on the rising edge, write-first.
  logic [7:0] sram [2][8][512];
  always @(posedge wb_clk_i) begin
    for (int u = 0; u < 2; u++) begin
      if (!cen[u]) begin
        for (int k = 0; k < 8; k++) begin
          if (!gwen[u][k]) begin
            sram[u][k][a_all[u]]  <= d_all[u];
            q_flat[u][k*8 +: 8]   <= d_all[u];
          end else begin
            q_flat[u][k*8 +: 8]   <= sram[u][k][a_all[u]];
          end
        end
      end
    end
  end

  // Reference model: window contents as a flat byte array, plus the response
  // owed in the next cycle.
  logic [7:0] ref_mem [2][WIN];
  int         base_of [2];
  bit         exp_v    [2];
  bit         exp_hit  [2];
  logic [7:0] exp_data [2];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic set_idle();
    for (int u = 0; u < 2; u++) begin
      req_valid[u]   = 1'b0;
      req_we[u]      = 1'b0;
      req_addr[u]    = '0;
      req_wdata[u]   = '0;
      clear_start[u] = 1'b0;
    end
  endtask

  task automatic set_req(input int u, input bit we, input logic [15:0] addr,
                         input logic [7:0] wd, input bit en);
    req_valid[u] = 1'b1;
    req_we[u]    = we;
    req_addr[u]  = addr;
    req_wdata[u] = wd;
    ram_en[u]    = en;
  endtask

  // One IDLE-state cycle on both units with the stimulus already applied.
  // The expected bus activity is derived from the window arithmetic.
  task automatic tick();
    bit   hit  [2];
    int   off  [2];
    int   bank [2];
    int   row  [2];
    logic [7:0] e_gwen;
    for (int u = 0; u < 2; u++) begin
      off[u]  = (int'(req_addr[u]) - base_of[u]) & 'h1ffff;
      hit[u]  = (int'(req_addr[u]) >= base_of[u]) && (off[u] < WIN) && ram_en[u];
      bank[u] = off[u] % 8;
      row[u]  = (off[u] / 8) % 512;
    end
    @(negedge wb_clk_i);
    for (int u = 0; u < 2; u++) begin
      e_gwen = (req_valid[u] && hit[u] && req_we[u]) ? ~(8'd1 << bank[u]) : 8'hFF;
      check($sformatf("u%0d_ready", u), req_ready[u], 1);
      check($sformatf("u%0d_busy", u), busy[u], 0);
      check($sformatf("u%0d_cen", u), cen[u], req_valid[u] ? !hit[u] : 1'b1);
      check($sformatf("u%0d_gwen", u), gwen[u], e_gwen);
      check($sformatf("u%0d_a", u), a_all[u], req_valid[u] ? row[u] : 0);
      check($sformatf("u%0d_d", u), d_all[u], req_valid[u] ? req_wdata[u] : 8'h00);
      check($sformatf("u%0d_wen", u), wen[u], 0);
      check($sformatf("u%0d_rsp_valid", u), rsp_valid[u], exp_v[u]);
      if (exp_v[u]) begin
        check($sformatf("u%0d_rsp_hit", u), rsp_hit[u], exp_hit[u]);
        check($sformatf("u%0d_rsp_data", u), rsp_rdata[u], exp_data[u]);
      end
      exp_v[u]    = req_valid[u] && !req_we[u];
      exp_hit[u]  = hit[u];
      exp_data[u] = hit[u] ? ref_mem[u][off[u]] : 8'h00;
      if (req_valid[u] && req_we[u] && hit[u]) ref_mem[u][off[u]] = req_wdata[u];
    end
    @(posedge wb_clk_i);
    #1;
    set_idle();
  endtask

  // n cycles of zero-fill on unit 0, starting at row 0.
  task automatic clear_run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge wb_clk_i);
      check("clr_busy", busy[0], 1);
      check("clr_ready", req_ready[0], 0);
      check("clr_cen", cen[0], 0);
      check("clr_gwen", gwen[0], 8'h00);
      check("clr_d", d_all[0], 8'h00);
      check("clr_a", a_all[0], i);
      @(posedge wb_clk_i);
      #1;
    end
  endtask

  task automatic check_reset_outputs();
    for (int u = 0; u < 2; u++) begin
      check($sformatf("rst_u%0d_cen", u), cen[u], 1);
      check($sformatf("rst_u%0d_gwen", u), gwen[u], 8'hFF);
      check($sformatf("rst_u%0d_ready", u), req_ready[u], 0);
      check($sformatf("rst_u%0d_busy", u), busy[u], 0);
    end
  endtask

  task automatic zero_model();
    for (int i = 0; i < WIN; i++) ref_mem[0][i] = 8'h00;
  endtask

  initial begin
    base_of[0] = 0;
    base_of[1] = 'h1000;
    for (int u = 0; u < 2; u++) begin
      exp_v[u]  = 1'b0;
      ram_en[u] = 1'b1;
      for (int k = 0; k < 8; k++)
        for (int r = 0; r < 512; r++) begin
          sram[u][k][r]          = 8'($urandom_range(1, 255));
          ref_mem[u][r * 8 + k]  = sram[u][k][r];
        end
    end
    set_idle();
    rst = 1'b1;
    repeat (2) @(posedge wb_clk_i);
    #1;
    @(negedge wb_clk_i);
    check_reset_outputs();
    check("rst_rsp_valid", rsp_valid[0], 0);
    check("rst_rsp_hit", rsp_hit[0], 0);
    @(posedge wb_clk_i);
    #1;
    rst = 1'b0;

    // Power-on zero-fill on unit 0; unit 1 comes out of reset idle.
    clear_run(512);
    zero_model();
    @(negedge wb_clk_i);
    check("post_clr_busy", busy[0], 0);
    check("post_clr_ready", req_ready[0], 1);
    check("u1_idle_ready", req_ready[1], 1);
    @(posedge wb_clk_i);
    #1;

    // Write then read-back of the same byte.
    set_req(0, 1'b1, 16'h0013, 8'hA5, 1'b1); tick();
    set_req(0, 1'b0, 16'h0013, 8'h00, 1'b1); tick();
    tick();

    // Window edges on unit 1.
    set_req(1, 1'b0, 16'h0FFF, 8'h00, 1'b1); tick();
    set_req(1, 1'b0, 16'h2000, 8'h00, 1'b1); tick();
    set_req(1, 1'b1, 16'h1FFF, 8'h3C, 1'b1); tick();
    set_req(1, 1'b0, 16'h1FFF, 8'h00, 1'b1); tick();
    set_req(1, 1'b0, 16'h1000, 8'h00, 1'b1); tick();
    tick();

    // Disabled write leaves the cleared byte untouched.
    set_req(0, 1'b1, 16'h0008, 8'h55, 1'b0); tick();
    set_req(0, 1'b0, 16'h0008, 8'h00, 1'b1); tick();
    tick();

    // Back-to-back reads covering all eight banks.
    for (int i = 0; i < 8; i++) begin
      set_req(0, 1'b0, 16'(i), 8'h00, 1'b1);
      tick();
    end
    tick();

    // Randomized traffic on both units.
    for (int n = 0; n < 600; n++) begin
      for (int u = 0; u < 2; u++) begin
        if ($urandom_range(0, 3) != 0) begin
          set_req(u, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0) ? 16'(base_of[u] + $urandom_range(0, WIN - 1))
                                              : 16'($urandom),
                  8'($urandom), $urandom_range(0, 9) != 0);
        end
      end
      tick();
    end
    tick();

    // clear_start beats a same-cycle request.
    set_req(0, 1'b1, 16'h0040, 8'h77, 1'b1);
    clear_start[0] = 1'b1;
    @(negedge wb_clk_i);
    check("cs_ready", req_ready[0], 0);
    check("cs_cen", cen[0], 1);
    check("cs_gwen", gwen[0], 8'hFF);
    check("cs_busy", busy[0], 0);
    @(posedge wb_clk_i);
    #1;
    set_idle();
    exp_v[0] = 1'b0;
    exp_v[1] = 1'b0;

    // Reset in the middle of the fill restarts it from row 0.
    clear_run(200);
    @(negedge wb_clk_i);
    check("mid_a", a_all[0], 200);
    check("mid_busy", busy[0], 1);
    rst = 1'b1;
    #1;
    check_reset_outputs();
    @(posedge wb_clk_i);
    #1;
    rst = 1'b0;
    clear_run(512);
    zero_model();
    @(negedge wb_clk_i);
    check("post_rst_busy", busy[0], 0);
    check("post_rst_ready", req_ready[0], 1);
    @(posedge wb_clk_i);
    #1;

    // Spot reads after the fill return zero.
    for (int n = 0; n < 16; n++) begin
      set_req(0, 1'b0, 16'($urandom_range(0, WIN - 1)), 8'h00, 1'b1);
      tick();
    end
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_bank_controller.md
Name: ram_bank_controller

Overview:
- Parametrised successor to the single-window byte RAM controller.
- Maps a window of the CPU address space onto NUM_BANKS byte-interleaved synchronous SRAM macros that share address and data lines.
- Adds a valid/ready request port, a registered read response with hit flag, and active-low chip-enable gating for power.
- Adds a zero-fill state machine that runs after reset or on command; it sits between the IO block bus and the SRAM macros.

Parameters:
- NUM_BANKS, 8, number of byte-wide macros; power of two, ≥2; BS = log2(NUM_BANKS).
- BANK_ADDR_W, 9, row address width of each macro.
- DATA_W, 8, data width of each macro.
- ADDR_W, 16, CPU address width.
- BASE_ADDR, 16'h0000, first address of the window. Window size SIZE = NUM_BANKS << BANK_ADDR_W.
- CLEAR_ON_RESET, 1, when 1, zero-fill runs after reset.

Ports:
- wb_clk_i  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active high.
- ram_enabled  in  1  global enable; when 0, accesses miss.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- clear_start  in  1  pulse; starts zero-fill from IDLE.
- busy  out  1  zero-fill in progress.
- rsp_valid  out  1  read response valid, one cycle.
- rsp_hit  out  1  response address was in window and enabled.
- rsp_rdata  out  DATA_W  read data; 0 on miss.
- CEN_all  out  1  shared chip enable, active low.
- WEN_all  out  DATA_W  bit-write mask, active low; constant 0.
- A_all  out  BANK_ADDR_W  shared row address.
- D_all  out  DATA_W  shared write data.
- GWEN  out  NUM_BANKS  per-bank global write enable, active low.
- Q_flat  in  NUM_BANKS*DATA_W  macro outputs; bank k at bits [k*DATA_W +: DATA_W].

Behaviour:
- Decode (combinational on req_addr):
  - off = req_addr - BASE_ADDR, computed in ADDR_W+1 bits.
  - in_range = req_addr ≥ BASE_ADDR && off < SIZE.
  - bank = off[BS-1:0]; row = off[BS+BANK_ADDR_W-1:BS].
  - hit = in_range && ram_enabled.
- States: CLEAR, IDLE.
  - On rst: state = CLEAR if CLEAR_ON_RESET, else IDLE; clr_cnt = 0.
  - Reset values: rsp_valid = 0, rsp_hit = 0, registered bank = 0.
  - During reset cycles: CEN_all = 1, GWEN = all 1, req_ready = 0, busy = 0.
- CLEAR:
  - busy = 1, req_ready = 0.
  - A_all = clr_cnt, D_all = 0, CEN_all = 0, GWEN = all 0.
  - clr_cnt increments each cycle. After the cycle with clr_cnt = 2^BANK_ADDR_W-1, go to IDLE and set clr_cnt = 0.
  - Total 2^BANK_ADDR_W cycles; clears every byte of the window.
  - rst during CLEAR restarts from row 0 (or goes to IDLE if CLEAR_ON_RESET=0).
- IDLE:
  - busy = 0; req_ready = !clear_start.
  - clear_start in IDLE goes to CLEAR next cycle; clear_start has priority over a same-cycle request, which is not accepted.
  - clear_start while in CLEAR is ignored.
- Accept cycle (req_valid && req_ready):
  - A_all = row, D_all = req_wdata.
  - CEN_all = !hit.
  - GWEN[bank] = !(hit && req_we); all other GWEN bits = 1.
  - Macros sample on the closing edge. Misses touch no macro; CEN_all stays high.
- Non-accept IDLE cycles: CEN_all = 1, GWEN = all 1, A_all = 0, D_all = 0.
- Read response:
  - An accepted read registers bank and hit.
  - Next cycle: rsp_valid = 1, rsp_hit = registered hit, rsp_rdata = registered hit ? Q_flat[bank] : 0. The mux is combinational from Q_flat.
  - Accepted writes produce no response.
- Throughput is one request per cycle with back-to-back reads and writes.
- A read of an address written in the previous cycle returns the new data (macro write-first).
- A response owed from the last IDLE cycle is still delivered in the first CLEAR cycle.
- ram_enabled is sampled in the accept cycle only.

Test Plan:
- Reset with CLEAR_ON_RESET=1, defaults → busy = 1 for exactly 512 cycles and req_ready = 0 throughout; every GWEN bit low, A_all counting 0..511; then busy = 0, req_ready = 1.
- Write 0xA5 at 0x0013, then read 0x0013 next cycle → write cycle shows GWEN = 8'b1111_0111, A_all = 2; read response one cycle later: rsp_valid = 1, rsp_hit = 1, rsp_rdata = 0xA5.
- BASE_ADDR=16'h1000: read 0x0FFF and 0x2000 → CEN_all = 1 on both, rsp_hit = 0, rsp_rdata = 0; read 0x1FFF → bank 7, row 511, rsp_hit = 1.
- ram_enabled=0, write 0x55 to 0x0008 → GWEN all 1, CEN_all = 1. Then ram_enabled=1, read 0x0008 → rsp_rdata = 0x00 (post-clear value).
- Back-to-back reads of 0x0000..0x0007 → rsp_valid high for 8 consecutive cycles, rsp_rdata matching the per-bank model.
- clear_start asserted with req_valid in the same cycle → req_ready = 0, request not accepted, busy = 1 next cycle. rst asserted mid-clear at row 200 → clear restarts at row 0 and runs a full 512 cycles.
